// File: rtl/internal_ram_arbiter.sv
// Arbiter that shares one single-port internal RAM between the instruction-fetch port and the data port.
// The data port has priority, a starvation counter forces fetch grants, and the bootloader ROM region is write-protected.
module internal_ram_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int ROM_WORDS    = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    i_rsp_valid,
  output logic [DATA_WIDTH-1:0]   i_rsp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_req_wr,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH/8-1:0] d_req_mask,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic                    d_rsp_err,
  output logic                    ram_en,
  output logic                    ram_wr,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH/8-1:0] ram_mask,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [7:0]              rom_violations
);

  localparam int MW = DATA_WIDTH / 8;
  localparam logic [3:0]          STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0] ROM_LIM    = (ADDR_WIDTH + 1)'(ROM_WORDS);

  logic [3:0] i_wait_q, i_wait_d;
  logic [7:0] rom_viol_q, rom_viol_d;
  logic       pend_i_q, pend_d_q, pend_wr_q, pend_err_q;
  logic       grant_i, grant_d, rom_block;

  // Handshake: a request transfers in the cycle where valid && ready; ready is
  // the combinational grant, and the response appears exactly one cycle later
  // with no backpressure.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (d_req_valid && !(i_req_valid && (i_wait_q >= STARVE_LIM))) begin
        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  assign rom_block   = grant_d && d_req_wr && ({1'b0, d_req_addr} < ROM_LIM);
  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // Blocked ROM writes are acknowledged but never reach the RAM.
  always_comb begin
    ram_en    = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_mask  = '0;
    ram_wdata = '0;
    if (grant_i) begin
      ram_en   = 1'b1;
      ram_addr = i_req_addr;
    end else if (grant_d && !rom_block) begin
      ram_en   = 1'b1;
      ram_addr = d_req_addr;
      if (d_req_wr) begin
        ram_wr    = 1'b1;
        ram_mask  = d_req_mask;
        ram_wdata = d_req_wdata;
      end
    end
  end

  always_comb begin
    i_wait_d = i_wait_q;
    if (!i_req_valid || grant_i) begin
      i_wait_d = 4'd0;
    end else if (i_wait_q < STARVE_LIM) begin
      i_wait_d = i_wait_q + 4'd1;
    end
  end

  always_comb begin
    rom_viol_d = rom_viol_q;
    if (rom_block && (rom_viol_q != 8'hFF)) begin
      rom_viol_d = rom_viol_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_wait_q   <= 4'd0;
      rom_viol_q <= 8'd0;
      pend_i_q   <= 1'b0;
      pend_d_q   <= 1'b0;
      pend_wr_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      i_wait_q   <= i_wait_d;
      rom_viol_q <= rom_viol_d;
      pend_i_q   <= grant_i;
      pend_d_q   <= grant_d;
      pend_wr_q  <= grant_d && d_req_wr;
      pend_err_q <= rom_block;
    end
  end

  // A reset in the response cycle suppresses the response and zeroes every output.
  assign i_rsp_valid    = pend_i_q && !reset;
  assign i_rsp_data     = i_rsp_valid ? ram_rdata : '0;
  assign d_rsp_valid    = pend_d_q && !reset;
  assign d_rsp_data     = (d_rsp_valid && !pend_wr_q) ? ram_rdata : '0;
  assign d_rsp_err      = d_rsp_valid && pend_err_q;
  assign rom_violations = reset ? 8'd0 : rom_viol_q;

  logic unused_mw;
  assign unused_mw = (MW == 0);

endmodule

// File: tb/tb_internal_ram_arbiter.sv
// Directed bench for internal_ram_arbiter with a behavioural 4096x32 RAM attached to the RAM port.
module tb_internal_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req_valid, i_req_ready;
  logic [11:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_wr;
  logic [11:0] d_req_addr;
  logic [3:0]  d_req_mask;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic        ram_en, ram_wr;
  logic [11:0] ram_addr;
  logic [3:0]  ram_mask;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [7:0]  rom_violations;

  int n_checks;
  int n_errors;

  logic [31:0] mem [4096];
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;

  internal_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wr(d_req_wr),
    .d_req_addr(d_req_addr), .d_req_mask(d_req_mask), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rom_violations(rom_violations)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM: registered read, byte-masked write
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (ram_en) begin
      if (ram_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_mask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic set_i(input logic v, input logic [11:0] addr);
    i_req_valid = v;
    i_req_addr  = addr;
  endtask

  task automatic set_d(input logic v, input logic wr, input logic [11:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata);
    d_req_valid = v;
    d_req_wr    = wr;
    d_req_addr  = addr;
    d_req_mask  = mask;
    d_req_wdata = wdata;
  endtask

  task automatic idle();
    set_i(1'b0, 12'h000);
    set_d(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    ram_rdata = '0;
    reset     = 1'b1;
    idle();

    preload(12'h010, 32'hDEADBEEF);
    preload(12'h401, 32'h11223344);
    preload(12'h3FF, 32'hCAFEF00D);
    preload(12'h500, 32'h55555555);
    preload(12'h501, 32'h55550001);
    preload(12'h600, 32'h66666666);

    // reset gates everything even with requests present
    @(negedge clk);
    set_i(1'b1, 12'h010);
    set_d(1'b1, 1'b0, 12'h500, 4'h0, 32'h0);
    #1;
    check("rst_i_ready", 32'(i_req_ready), 32'd0);
    check("rst_d_ready", 32'(d_req_ready), 32'd0);
    check("rst_ram_en",  32'(ram_en), 32'd0);
    check("rst_rom_viol", 32'(rom_violations), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("post_rst_i_rsp", 32'(i_rsp_valid), 32'd0);
    check("post_rst_d_rsp", 32'(d_rsp_valid), 32'd0);
    @(negedge clk);

    // fetch only
    set_i(1'b1, 12'h010);
    #1;
    check("fetch_ram_en",   32'(ram_en), 32'd1);
    check("fetch_ram_addr", 32'(ram_addr), 32'h010);
    check("fetch_i_ready",  32'(i_req_ready), 32'd1);
    check("fetch_ram_wr",   32'(ram_wr), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("fetch_rsp_valid", 32'(i_rsp_valid), 32'd1);
    check("fetch_rsp_data",  i_rsp_data, 32'hDEADBEEF);
    check("fetch_d_rsp",     32'(d_rsp_valid), 32'd0);
    @(negedge clk);

    // data write then read-back; new grant alongside the ack
    set_d(1'b1, 1'b1, 12'h400, 4'hF, 32'h12345678);
    #1;
    check("wr_ram_wr",    32'(ram_wr), 32'd1);
    check("wr_ram_mask",  32'(ram_mask), 32'hF);
    check("wr_ram_wdata", ram_wdata, 32'h12345678);
    check("wr_ram_addr",  32'(ram_addr), 32'h400);
    @(negedge clk);
    set_d(1'b1, 1'b0, 12'h400, 4'h0, 32'h0);
    #1;
    check("wr_ack_valid", 32'(d_rsp_valid), 32'd1);
    check("wr_ack_err",   32'(d_rsp_err), 32'd0);
    check("wr_ack_data",  d_rsp_data, 32'd0);
    check("rd_overlap_ready", 32'(d_req_ready), 32'd1);
    check("rd_ram_wr",    32'(ram_wr), 32'd0);
    check("rd_ram_mask",  32'(ram_mask), 32'd0);
    @(negedge clk);
    set_d(1'b1, 1'b1, 12'h401, 4'h5, 32'hAABBCCDD);
    #1;
    check("rd_400_data", d_rsp_data, 32'h12345678);
    check("rd_400_err",  32'(d_rsp_err), 32'd0);
    @(negedge clk);
    set_d(1'b1, 1'b0, 12'h401, 4'h0, 32'h0);
    #1;
    check("wr_401_ack", 32'(d_rsp_valid), 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("rd_401_masked", d_rsp_data, 32'h11BB33DD);
    @(negedge clk);

    // ROM protection and violation counter saturation
    set_d(1'b1, 1'b1, 12'h3FF, 4'h1, 32'hFFFFFFFF);
    #1;
    check("rom_d_ready", 32'(d_req_ready), 32'd1);
    check("rom_ram_en",  32'(ram_en), 32'd0);
    check("rom_ram_wr",  32'(ram_wr), 32'd0);
    check("rom_viol_0",  32'(rom_violations), 32'd0);
    @(negedge clk);
    set_d(1'b1, 1'b1, 12'h000, 4'h0, 32'h0);
    #1;
    check("rom_ack_valid", 32'(d_rsp_valid), 32'd1);
    check("rom_ack_err",   32'(d_rsp_err), 32'd1);
    check("rom_ack_data",  d_rsp_data, 32'd0);
    check("rom_viol_1",    32'(rom_violations), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 298; k++) begin
      set_d(1'b1, 1'b1, 12'(k), 4'hF, 32'h0BAD0BAD);
      if (k == 0) begin
        #1;
        check("rom_viol_mask0", 32'(rom_violations), 32'd2);
      end
      @(negedge clk);
    end
    idle();
    #1;
    check("rom_viol_sat", 32'(rom_violations), 32'd255);
    check("rom_err_last", 32'(d_rsp_err), 32'd1);
    check("rom_word_kept", mem[12'h3FF], 32'hCAFEF00D);
    @(negedge clk);

    // starvation: d,d,d,d,i,d with both held valid
    set_d(1'b1, 1'b0, 12'h500, 4'h0, 32'h0);
    set_i(1'b1, 12'h600);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("starve_d_ready_%0d", k), 32'(d_req_ready), 32'(k != 4));
      check($sformatf("starve_i_ready_%0d", k), 32'(i_req_ready), 32'(k == 4));
      check($sformatf("starve_i_rsp_%0d", k),   32'(i_rsp_valid), 32'(k == 5));
      check($sformatf("starve_d_rsp_%0d", k),   32'(d_rsp_valid), 32'(k >= 1 && k != 5));
      if (k == 5) check("starve_i_data", i_rsp_data, 32'h66666666);
      @(negedge clk);
    end
    idle();
    #1;
    check("starve_tail_i", 32'(i_rsp_valid), 32'd0);
    check("starve_tail_d", d_rsp_data, 32'h55555555);
    @(negedge clk);

    // alternating single-cycle requests
    set_d(1'b1, 1'b0, 12'h500, 4'h0, 32'h0);
    #1;
    check("alt_d0_ready", 32'(d_req_ready), 32'd1);
    @(negedge clk);
    idle();
    set_i(1'b1, 12'h600);
    #1;
    check("alt_d0_valid", 32'(d_rsp_valid), 32'd1);
    check("alt_d0_data",  d_rsp_data, 32'h55555555);
    check("alt_d0_i_valid", 32'(i_rsp_valid), 32'd0);
    check("alt_d0_i_data",  i_rsp_data, 32'd0);
    @(negedge clk);
    idle();
    set_d(1'b1, 1'b0, 12'h501, 4'h0, 32'h0);
    #1;
    check("alt_i_valid", 32'(i_rsp_valid), 32'd1);
    check("alt_i_data",  i_rsp_data, 32'h66666666);
    check("alt_i_d_valid", 32'(d_rsp_valid), 32'd0);
    check("alt_i_d_data",  d_rsp_data, 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("alt_d1_data",  d_rsp_data, 32'h55550001);
    check("alt_d1_i_valid", 32'(i_rsp_valid), 32'd0);
    @(negedge clk);

    // reset in the response cycle
    set_i(1'b1, 12'h010);
    #1;
    check("rr_i_ready", 32'(i_req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    set_d(1'b1, 1'b0, 12'h500, 4'h0, 32'h0);
    #1;
    check("rr_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    check("rr_i_rsp_data",  i_rsp_data, 32'd0);
    check("rr_i_ready_rst", 32'(i_req_ready), 32'd0);
    check("rr_d_ready_rst", 32'(d_req_ready), 32'd0);
    check("rr_ram_en",      32'(ram_en), 32'd0);
    check("rr_rom_viol",    32'(rom_violations), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rr_first_d",  32'(d_req_ready), 32'd1);
    check("rr_first_i",  32'(i_req_ready), 32'd0);
    check("rr_no_stale", 32'(i_rsp_valid), 32'd0);
    check("rr_viol_clr", 32'(rom_violations), 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("rr_d_rsp", d_rsp_data, 32'h55555555);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
